// File: rtl/sync_barrier_pkg.sv
// Shared types and default parameters for the sync_barrier block.
package sync_barrier_pkg;

  localparam int unsigned N_DEFAULT              = 4;
  localparam int unsigned EPOCH_W_DEFAULT        = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RELEASE = 2'd2
  } barrier_state_t;

endpackage

// File: rtl/and_reduce_tree.sv
// Balanced binary tree of 2-input ANDs; purely combinational reduction of in_i.
module and_reduce_tree #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] in_i,
  output logic         out_c
);

  generate
    if (W == 1) begin : g_leaf
      assign out_c = in_i[0];
    end else begin : g_node
      localparam int unsigned WL = W / 2;
      localparam int unsigned WH = W - WL;
      logic lo_c;
      logic hi_c;

      and_reduce_tree #(.W(WL)) u_lo (
        .in_i  (in_i[WL-1:0]),
        .out_c (lo_c)
      );

      and_reduce_tree #(.W(WH)) u_hi (
        .in_i  (in_i[W-1:WL]),
        .out_c (hi_c)
      );

      assign out_c = lo_c & hi_c;
    end
  endgenerate

endmodule

// File: rtl/sync_barrier.sv
// Sticky per-lane arrival barrier with a valid/ready release and epoch count.
// Optional forced release on COLLECT timeout: define SYNC_BARRIER_TIMEOUT_EN.
module sync_barrier
  import sync_barrier_pkg::*;
#(
  parameter int unsigned N              = N_DEFAULT,
  parameter int unsigned EPOCH_W        = EPOCH_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       arrive,
  input  logic [N-1:0]       lane_en,
  input  logic               release_ready,
  output logic               release_valid,
  output logic [N-1:0]       arrived,
  output logic [EPOCH_W-1:0] epoch,
  output logic               busy,
  output logic               overrun,
  output logic               release_partial
);

  generate
    if (N < 2) begin : g_bad_n
      $error("sync_barrier: N must be >= 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("sync_barrier: TIMEOUT_CYCLES must be >= 2");
    end
  endgenerate

  barrier_state_t     state_q, state_d;
  logic [N-1:0]       arrived_q, arrived_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               overrun_q, overrun_d;

  logic [N-1:0] arrive_en_c;
  logic [N-1:0] nxt_c;
  logic         all_in_c;
  logic         done_c;

`ifdef SYNC_BARRIER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             partial_q, partial_d;
`endif

  assign arrive_en_c = arrive & lane_en;
  assign nxt_c       = arrived_q | arrive_en_c;

  // Disabled lanes are treated as already arrived.
  and_reduce_tree #(.W(N)) u_and_tree (
    .in_i  (nxt_c | ~lane_en),
    .out_c (all_in_c)
  );

  assign done_c = all_in_c && (lane_en != '0);

  always_comb begin
    state_d   = state_q;
    arrived_d = arrived_q;
    epoch_d   = epoch_q;
    overrun_d = overrun_q;
`ifdef SYNC_BARRIER_TIMEOUT_EN
    cnt_d     = '0;
    partial_d = partial_q;
`endif
    case (state_q)
      IDLE: begin
        arrived_d = nxt_c;
        if (done_c) begin
          state_d = RELEASE;
        end else if (nxt_c != '0) begin
          state_d = COLLECT;
`ifdef SYNC_BARRIER_TIMEOUT_EN
          cnt_d   = CNT_W'(1);
`endif
        end
      end
      COLLECT: begin
        arrived_d = nxt_c;
        if (done_c) begin
          state_d = RELEASE;
`ifdef SYNC_BARRIER_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d   = RELEASE;
          partial_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      RELEASE: begin
        // Arrivals here belong to no phase: drop them and flag.
        if (arrive_en_c != '0) begin
          overrun_d = 1'b1;
        end
        if (release_ready) begin
          arrived_d = '0;
          epoch_d   = epoch_q + EPOCH_W'(1);
          state_d   = IDLE;
`ifdef SYNC_BARRIER_TIMEOUT_EN
          partial_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      arrived_q <= '0;
      epoch_q   <= '0;
      overrun_q <= 1'b0;
`ifdef SYNC_BARRIER_TIMEOUT_EN
      cnt_q     <= '0;
      partial_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      epoch_q   <= epoch_d;
      overrun_q <= overrun_d;
`ifdef SYNC_BARRIER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      partial_q <= partial_d;
`endif
    end
  end

  assign release_valid = (state_q == RELEASE);
  assign busy          = (state_q != IDLE);
  assign arrived       = arrived_q;
  assign epoch         = epoch_q;
  assign overrun       = overrun_q;

`ifdef SYNC_BARRIER_TIMEOUT_EN
  assign release_partial = partial_q;
`else
  assign release_partial = 1'b0;
`endif

endmodule

// File: tb/tb_sync_barrier.sv
// Self-checking bench for sync_barrier: directed scenarios plus random traffic
// compared against a lane-level behavioural model.
module tb_sync_barrier;

  localparam int unsigned N  = 4;
  localparam int unsigned EW = 8;
  localparam int unsigned TO = 16;

  logic          clock;
  logic          reset;
  logic [N-1:0]  arrive;
  logic [N-1:0]  lane_en;
  logic          release_ready;
  logic          release_valid;
  logic [N-1:0]  arrived;
  logic [EW-1:0] epoch;
  logic          busy;
  logic          overrun;
  logic          release_partial;

  int total = 0;
  int bad   = 0;

  // Model: phase 0=waiting with nobody in, 1=gathering, 2=released
  int           m_phase;
  bit [N-1:0]   m_arr;
  int           m_epoch;
  bit           m_over;
  bit           m_part;
  int           m_wait;

  sync_barrier #(.N(N), .EPOCH_W(EW), .TIMEOUT_CYCLES(TO)) dut (
    .clock           (clock),
    .reset           (reset),
    .arrive          (arrive),
    .lane_en         (lane_en),
    .release_ready   (release_ready),
    .release_valid   (release_valid),
    .arrived         (arrived),
    .epoch           (epoch),
    .busy            (busy),
    .overrun         (overrun),
    .release_partial (release_partial)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit [N-1:0] a, input bit [N-1:0] en, input bit rdy, input bit rst);
    bit complete;
    if (rst) begin
      m_phase = 0; m_arr = '0; m_epoch = 0; m_over = 0; m_part = 0; m_wait = 0;
    end else if (m_phase == 2) begin
      for (int i = 0; i < N; i++) if (a[i] && en[i]) m_over = 1;
      if (rdy) begin
        m_arr = '0; m_epoch = (m_epoch + 1) % (1 << EW); m_phase = 0; m_part = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) if (a[i] && en[i]) m_arr[i] = 1;
      complete = (en != '0);
      for (int i = 0; i < N; i++) if (en[i] && !m_arr[i]) complete = 0;
      if (complete) begin
        m_phase = 2;
      end else if (m_phase == 0) begin
        if (m_arr != '0) begin
          m_phase = 1; m_wait = 1;
        end
      end else begin
`ifdef SYNC_BARRIER_TIMEOUT_EN
        if (m_wait == TO) begin
          m_phase = 2; m_part = 1;
        end else begin
          m_wait++;
        end
`endif
      end
    end
  endtask

  task automatic cycle(input bit [N-1:0] a, input bit [N-1:0] en, input bit rdy, input bit rst);
    arrive = a; lane_en = en; release_ready = rdy; reset = rst;
    @(posedge clock);
    model_step(a, en, rdy, rst);
    #1;
    check("release_valid", 32'(release_valid), 32'(m_phase == 2));
    check("busy",          32'(busy),          32'(m_phase != 0));
    check("arrived",       32'(arrived),       32'(m_arr));
    check("epoch",         32'(epoch),         32'(m_epoch));
    check("overrun",       32'(overrun),       32'(m_over));
    check("release_partial", 32'(release_partial), 32'(m_part));
  endtask

  initial begin
    bit [N-1:0] ren;
    bit [N-1:0] ra;
    arrive = '0; lane_en = '0; release_ready = 1'b0; reset = 1'b1;
    m_phase = 0; m_arr = '0; m_epoch = 0; m_over = 0; m_part = 0; m_wait = 0;
    @(negedge clock);
    cycle('0, 4'hF, 0, 1);
    cycle('0, 4'hF, 0, 1);
    check("reset_epoch", 32'(epoch), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);

    // Staggered arrivals 0,2,1,3
    cycle(4'b0001, 4'hF, 0, 0); check("t1_arr0", 32'(arrived), 32'h1);
    cycle(4'b0000, 4'hF, 0, 0);
    cycle(4'b0100, 4'hF, 0, 0); check("t1_arr2", 32'(arrived), 32'h5);
    cycle(4'b0000, 4'hF, 0, 0);
    cycle(4'b0010, 4'hF, 0, 0); check("t1_arr1", 32'(arrived), 32'h7);
    check("t1_no_rel", 32'(release_valid), 32'd0);
    cycle(4'b0000, 4'hF, 0, 0);
    cycle(4'b1000, 4'hF, 0, 0); check("t1_rel", 32'(release_valid), 32'd1);
    cycle(4'b0000, 4'hF, 0, 0);
    cycle(4'b0000, 4'hF, 1, 0);
    check("t1_epoch", 32'(epoch), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);

    // All lanes at once skip COLLECT
    cycle(4'b1111, 4'hF, 0, 0);
    check("t2_rel", 32'(release_valid), 32'd1);
    cycle(4'b0000, 4'hF, 1, 0);

    // Lane 2 disabled; its pulse is ignored
    cycle(4'b0011, 4'b1011, 0, 0);
    cycle(4'b0100, 4'b1011, 0, 0); check("t3_ign2", 32'(arrived), 32'h3);
    cycle(4'b1000, 4'b1011, 0, 0);
    check("t3_rel", 32'(release_valid), 32'd1);
    check("t3_arr", 32'(arrived), 32'hB);
    cycle(4'b0000, 4'b1011, 1, 0);
    // Dropping the missing lane mid-COLLECT completes
    cycle(4'b1011, 4'hF, 0, 0); check("t3b_wait", 32'(release_valid), 32'd0);
    cycle(4'b0000, 4'b1011, 0, 0); check("t3b_rel", 32'(release_valid), 32'd1);
    cycle(4'b0000, 4'b1011, 1, 0);

    // Stall in RELEASE with an overrun pulse
    cycle(4'b1111, 4'hF, 0, 0);
    for (int k = 0; k < 5; k++) cycle(4'b0010, 4'hF, 0, 0);
    check("t4_hold", 32'(arrived), 32'hF);
    check("t4_over", 32'(overrun), 32'd1);
    cycle(4'b0000, 4'hF, 1, 0);
    check("t4_over_sticky", 32'(overrun), 32'd1);

    // Reset mid-handshake beats acceptance
    cycle(4'b1111, 4'hF, 0, 0);
    cycle(4'b0000, 4'hF, 1, 1);
    check("t5_epoch", 32'(epoch), 32'd0);
    check("t5_valid", 32'(release_valid), 32'd0);
    check("t5_over", 32'(overrun), 32'd0);

    // Epoch wraps after 256 releases
    for (int k = 1; k <= 256; k++) begin
      cycle(4'b1111, 4'hF, 0, 0);
      cycle(4'b0000, 4'hF, 1, 0);
      if (k == 255) check("t4_ep255", 32'(epoch), 32'd255);
    end
    check("t4_wrap", 32'(epoch), 32'd0);

    // Only lane 0 arrives
    cycle('0, 4'hF, 0, 1);
    cycle(4'b0001, 4'hF, 0, 0);
    for (int k = 1; k <= 100; k++) begin
      cycle(4'b0000, 4'hF, 0, 0);
      if (k == 15) check("t6_pre", 32'(release_valid), 32'd0);
`ifdef SYNC_BARRIER_TIMEOUT_EN
      if (k == 16) begin
        check("t6_rel", 32'(release_valid), 32'd1);
        check("t6_part", 32'(release_partial), 32'd1);
        check("t6_arr", 32'(arrived), 32'h1);
      end
`else
      if (k == 100) check("t6_norel", 32'(release_valid), 32'd0);
`endif
    end
    cycle('0, 4'hF, 1, 1);

    // Random traffic
    ren = 4'hF;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) ren = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      cycle(ra, ren, $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
